stack_ctrl: RTL
===============

// Module: stack_ctrl
// PURPOSE
//  Command-side driver for the STACK data stack: turns opcodes (PUSH/DROP/DUP/SWAP/OVER/REPL/REDUCE)
//  into we/delta/wd strobe sequences, tracks depth and flags over/underflow. Sits between the core
//  decoder (cmd_* valid/ready) and one STACK instance (stk_* ports). STACK holds one head + DEPTH tail.
// PARAMETERS
//  DEPTH  8  tail entries in the attached STACK; capacity = DEPTH+1
//  WIDTH  8  data width
// PORTS
//  clk        in   1        sole clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  cmd_valid  in   1        command offered
//  cmd_ready  out  1        controller can accept this cycle
//  cmd_op     in   3        0 NOP,1 PUSH,2 DROP,3 DUP,4 SWAP,5 OVER,6 REPL,7 REDUCE
//  cmd_data   in   WIDTH    operand for PUSH/REPL/REDUCE
//  top        out  WIDTH    = stk_rd (current top of stack)
//  depth      out  $clog2(DEPTH+2)  live entries, 0..DEPTH+1
//  err_ovf    out  1        sticky overflow
//  err_unf    out  1        sticky underflow
//  hwm        out  $clog2(DEPTH+2)  depth high-water mark (see CONFIGURATION)
//  stk_rd     in   WIDTH    STACK head
//  stk_we     out  1        STACK write enable
//  stk_delta  out  2        STACK delta: [1]=pop/0=push, [0]=move
//  stk_wd     out  WIDTH    STACK write data
// BEHAVIOUR
//  Reset: FSM IDLE, depth=0, err_*=0, hwm=0, cmd_ready=1, stk_we=0, stk_delta=00. Stack RAM not
//   cleared; depth=0 marks it empty. Reset wins over any in-flight op, including mid SWAP/OVER.
//  Accept = cmd_valid & cmd_ready. In IDLE, strobes for step 1 are driven combinationally in the
//   accept cycle; STACK updates on that edge. Idle/non-accept cycles: stk_we=0, stk_delta=00.
//  Single-cycle ops (cmd_ready stays 1, back-to-back allowed):
//   PUSH  we=1 wd=cmd_data delta=01, depth+1 | DROP  we=0 delta=11, depth-1
//   DUP   we=1 wd=stk_rd delta=01, depth+1   | REPL  we=1 wd=cmd_data delta=00, depth same
//   REDUCE we=1 wd=cmd_data delta=11 (drop 2, push result), depth-1 | NOP no strobes
//  Multi-cycle ops, FSM IDLE->S2->S3->IDLE, cmd_ready=0 in S2,S3; temps t,u (WIDTH regs):
//   SWAP (b a -- a b): IDLE t<=a, pop; S2 u<=b, we=1 wd=t delta=00; S3 we=1 wd=u delta=01. depth same.
//   OVER (b a -- b a b): IDLE t<=a, pop; S2 u<=b, push t (delta=01); S3 push u. depth+1.
//  Checks at accept, against depth before the op: PUSH/DUP need depth<=DEPTH (DUP also >=1);
//   DROP/REPL need >=1; SWAP/REDUCE need >=2; OVER needs >=2 and <=DEPTH.
//   Failing cmd is still accepted (handshake completes) but issues no strobes, depth unchanged;
//   sets err_ovf (too full) or err_unf (too empty). Flags clear only on rst.
//  depth updates on the accept edge for all ops (net change applied once, even for SWAP/OVER).
//  top is combinational from stk_rd; valid only when depth!=0, otherwise don't-care.
// CONFIGURATION
//  STACK_CTRL_HWM_EN defined: hwm tracks max depth since reset, updated the edge depth rises.
//  Undefined: hwm tied to 0, no tracking register; all other behaviour identical.
// STRUCTURE
//  Package stack_pkg: opcode typedef enum (3 bit), localparams DELTA_HOLD=2'b00, DELTA_PUSH=2'b01,
//   DELTA_POP=2'b11, FSM state typedef. Shared with the decoder and STACK testbench.
//  Sub-module stack_depth_ctr: depth counter, bounds checks, err flags, optional hwm.
//   FSM and temps stay in stack_ctrl.
// TESTING (bench instantiates STACK DEPTH=4 WIDTH=8 behind stack_ctrl)
//  PUSH 11,22,33 back-to-back -> top=33, depth=3, cmd_ready high throughout, no errors.
//  From 11,22,33: SWAP -> cmd_ready low 2 cycles, then top=22, DROP -> top=33, DROP -> 11.
//  From 11,22: OVER -> top=11, then 22, 11 on successive DROPs, depth 3->0.
//  Push 5 values (full), PUSH 0x99 -> err_ovf=1, depth=5, top unchanged; DUP also rejected.
//  Empty: DROP -> err_unf=1, depth=0, stk_delta=00; REDUCE on depth 1 -> err_unf, no strobes.
//  Assert rst in SWAP S2 -> next cycle IDLE, depth=0, cmd_ready=1, strobes 0.
//  With STACK_CTRL_HWM_EN: push 3, drop 2, push 1 -> hwm=3; without: hwm=0.

Source files
------------

// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the STACK command controller: the 3-bit opcode set
// used by the core decoder, the STACK delta encodings, and the controller
// FSM state type. Also used by the STACK testbench.
//
// Contents:
//   stack_op_e      opcode enum (NOP, PUSH, DROP, DUP, SWAP, OVER, REPL, REDUCE)
//   DELTA_HOLD      STACK delta: head rewritten in place, no movement
//   DELTA_PUSH      STACK delta: push (head moves into tail)
//   DELTA_POP       STACK delta: pop (tail moves into head)
//   stack_state_e   controller FSM states (IDLE, S2, S3)
//   opGrows()       opcode adds one entry when legal
//   opShrinks()     opcode removes one entry when legal
//   opMinDepth()    entries an opcode needs on the stack before it runs
// ---------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_PUSH   = 3'd1,
        OP_DROP   = 3'd2,
        OP_DUP    = 3'd3,
        OP_SWAP   = 3'd4,
        OP_OVER   = 3'd5,
        OP_REPL   = 3'd6,
        OP_REDUCE = 3'd7
    } stack_op_e;

    localparam logic [1:0] DELTA_HOLD = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_POP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S2   = 2'd1,
        ST_S3   = 2'd2
    } stack_state_e;

    // Ops whose net effect adds an entry; these are also the ones that can
    // overflow a full stack.
    function automatic logic opGrows(input stack_op_e op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

    // Ops whose net effect removes an entry.
    function automatic logic opShrinks(input stack_op_e op);
        return (op == OP_DROP) || (op == OP_REDUCE);
    endfunction

    // Minimum live entries an op has to find on the stack.
    function automatic logic [1:0] opMinDepth(input stack_op_e op);
        logic [1:0] need;
        need = 2'd0;
        case (op)
            OP_DROP, OP_DUP, OP_REPL:     need = 2'd1;
            OP_SWAP, OP_OVER, OP_REDUCE:  need = 2'd2;
            default:                      need = 2'd0;
        endcase
        return need;
    endfunction

endpackage

// File: rtl/stack_depth_ctr.sv
// ---------------------------------------------------------------------------
// stack_depth_ctr
// Live-entry counter for the STACK controller. Judges every command against
// the depth it finds, applies the net depth change on the accept edge, and
// keeps sticky overflow/underflow flags plus an optional high-water mark.
//
// Configuration:
//   STACK_CTRL_HWM_EN  defined   -> hwm_o tracks the largest depth since reset
//                      undefined -> hwm_o tied to zero, no register built
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   accept_i   in   a command is being accepted this cycle
//   op_i       in   opcode of the offered command
//   legal_o    out  offered command passes its depth checks
//   depth_o    out  live entries, 0..DEPTH+1
//   err_ovf_o  out  sticky overflow flag
//   err_unf_o  out  sticky underflow flag
//   hwm_o      out  depth high-water mark
// ---------------------------------------------------------------------------
module stack_depth_ctr
    import stack_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          accept_i,
    input  stack_op_e                     op_i,
    output logic                          legal_o,
    output logic [$clog2(DEPTH+2)-1:0]    depth_o,
    output logic                          err_ovf_o,
    output logic                          err_unf_o,
    output logic [$clog2(DEPTH+2)-1:0]    hwm_o
);

    localparam int DW = $clog2(DEPTH + 2);

    // A growing op is only allowed while at least one slot is free, i.e.
    // depth has not yet reached the full capacity of DEPTH+1.
    localparam logic [DW-1:0] MAX_GROW_DEPTH = DW'(DEPTH);

    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          tooFull, tooEmpty;

    // Depth checks look at the depth before the op. An op that is too full
    // and one that is too empty cannot coincide for any opcode, so the two
    // flags never get set by the same command.
    always_comb begin
        tooFull  = opGrows(op_i) && (depth_q > MAX_GROW_DEPTH);
        tooEmpty = depth_q < DW'(opMinDepth(op_i));
        legal_o  = !tooFull && !tooEmpty;
    end

    // Net depth change is applied once on the accept edge, even for the
    // multi-cycle ops; a rejected command leaves depth alone but raises the
    // matching sticky flag.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (accept_i) begin
            if (legal_o) begin
                if (opGrows(op_i)) begin
                    depth_d = depth_q + DW'(1);
                end else if (opShrinks(op_i)) begin
                    depth_d = depth_q - DW'(1);
                end
            end else begin
                ovf_d = ovf_q | tooFull;
                unf_d = unf_q | tooEmpty;
            end
        end
    end

    // Counter and flags; the flags only ever clear through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef STACK_CTRL_HWM_EN
    logic [DW-1:0] hwm_q, hwm_d;

    // High-water mark follows the next depth so it moves on the same edge
    // that depth rises.
    always_comb begin
        hwm_d = hwm_q;
        if (depth_d > hwm_q) begin
            hwm_d = depth_d;
        end
    end

    // High-water mark register, cleared by reset only.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`else
    assign hwm_o = '0;
`endif

    assign depth_o   = depth_q;
    assign err_ovf_o = ovf_q;
    assign err_unf_o = unf_q;

endmodule

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
// Command-side driver for one STACK instance. Turns decoder opcodes into the
// STACK we/delta/wd strobe sequences, runs the three-step SWAP and OVER
// sequences, and reports depth plus sticky over/underflow flags.
//
// Configuration:
//   STACK_CTRL_HWM_EN  enables the depth high-water mark on 'hwm'
//                      (otherwise 'hwm' reads zero)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  controller can accept this cycle
//   cmd_op     in   opcode (see stack_op_e)
//   cmd_data   in   operand for PUSH/REPL/REDUCE
//   top        out  current top of stack (meaningful only when depth != 0)
//   depth      out  live entries, 0..DEPTH+1
//   err_ovf    out  sticky overflow
//   err_unf    out  sticky underflow
//   hwm        out  depth high-water mark
//   stk_rd     in   STACK head value
//   stk_we     out  STACK write enable
//   stk_delta  out  STACK delta ([1]=pop/0=push, [0]=move)
//   stk_wd     out  STACK write data
// ---------------------------------------------------------------------------
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [WIDTH-1:0]              cmd_data,
    output logic [WIDTH-1:0]              top,
    output logic [$clog2(DEPTH+2)-1:0]    depth,
    output logic                          err_ovf,
    output logic                          err_unf,
    output logic [$clog2(DEPTH+2)-1:0]    hwm,
    input  logic [WIDTH-1:0]              stk_rd,
    output logic                          stk_we,
    output logic [1:0]                    stk_delta,
    output logic [WIDTH-1:0]              stk_wd
);

    stack_state_e     state_q, state_d;
    logic [WIDTH-1:0] tempT_q, tempT_d;
    logic [WIDTH-1:0] tempU_q, tempU_d;
    logic             isSwap_q, isSwap_d;
    stack_op_e        opIn;
    logic             accept;
    logic             legal;

    assign opIn      = stack_op_e'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign top       = stk_rd;

    // Depth bookkeeping, legality checks and error flags live in the
    // counter; this module only decides which strobes to emit.
    stack_depth_ctr #(
        .DEPTH     (DEPTH)
    ) u_depth (
        .clk       (clk),
        .rst       (rst),
        .accept_i  (accept),
        .op_i      (opIn),
        .legal_o   (legal),
        .depth_o   (depth),
        .err_ovf_o (err_ovf),
        .err_unf_o (err_unf),
        .hwm_o     (hwm)
    );

    // Strobe generation and next-state logic. Single-cycle ops strobe the
    // STACK in the accept cycle itself. SWAP and OVER share one sequence:
    // pop the old top into t, then in S2 capture the exposed second entry
    // into u while writing t back (rewrite in place for SWAP, push for
    // OVER), and finally push u in S3. Strobes are suppressed while reset
    // is asserted so an interrupted sequence never disturbs the STACK.
    always_comb begin
        state_d   = state_q;
        tempT_d   = tempT_q;
        tempU_d   = tempU_q;
        isSwap_d  = isSwap_q;
        stk_we    = 1'b0;
        stk_delta = DELTA_HOLD;
        stk_wd    = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept && legal) begin
                    case (opIn)
                        OP_PUSH: begin
                            stk_we    = 1'b1;
                            stk_wd    = cmd_data;
                            stk_delta = DELTA_PUSH;
                        end
                        OP_DROP: begin
                            stk_delta = DELTA_POP;
                        end
                        OP_DUP: begin
                            stk_we    = 1'b1;
                            stk_wd    = stk_rd;
                            stk_delta = DELTA_PUSH;
                        end
                        OP_REPL: begin
                            stk_we    = 1'b1;
                            stk_wd    = cmd_data;
                            stk_delta = DELTA_HOLD;
                        end
                        OP_REDUCE: begin
                            stk_we    = 1'b1;
                            stk_wd    = cmd_data;
                            stk_delta = DELTA_POP;
                        end
                        OP_SWAP, OP_OVER: begin
                            tempT_d   = stk_rd;
                            isSwap_d  = (opIn == OP_SWAP);
                            stk_delta = DELTA_POP;
                            state_d   = ST_S2;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_S2: begin
                tempU_d   = stk_rd;
                stk_we    = 1'b1;
                stk_wd    = tempT_q;
                stk_delta = isSwap_q ? DELTA_HOLD : DELTA_PUSH;
                state_d   = ST_S3;
            end
            ST_S3: begin
                stk_we    = 1'b1;
                stk_wd    = tempU_q;
                stk_delta = DELTA_PUSH;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rst) begin
            stk_we    = 1'b0;
            stk_delta = DELTA_HOLD;
        end
    end

    // FSM state register; reset abandons any SWAP/OVER in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequence temporaries carry no meaning outside a SWAP/OVER, so they
    // are left out of reset.
    always_ff @(posedge clk) begin
        tempT_q  <= tempT_d;
        tempU_q  <= tempU_d;
        isSwap_q <= isSwap_d;
    end

endmodule
